// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot loader, CPU top and instruction memory:
// loader state encoding, default word-index width and stream geometry.
package imem_loader_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 8;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
  localparam int unsigned BYTE_OFF_W     = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHK,
    ST_DONE,
    ST_ERR
  } loader_state_e;

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words and flags the byte
// that completes each word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_full_c_o
);

  logic [WORD_W-1:0]     word_q, word_d;
  logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      word_d = {word_q[WORD_W-BYTE_W-1:0], byte_i};
      cnt_d  = cnt_q + BYTE_CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o        = word_q;
  assign word_full_c_o = shift_i && !clear_i &&
                         (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: receives length/words/checksum over valid-ready, writes
// words to instruction memory from address 0 and releases the CPU hold.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic                   imem_we,
  output logic [ADDR_W+1:0]      imem_addr,
  output logic [31:0]            imem_wdata,
  output logic                   cpu_hold,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  loader_state_e         state_q, state_d;
  logic [ADDR_W-1:0]     len_q, len_d;
  logic [ADDR_W-1:0]     word_idx_q, word_idx_d;
  logic [BYTE_W-1:0]     chk_q, chk_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  asm_clear, asm_shift, word_full;
  logic                  accept;
  logic [WORD_W-1:0]     word;

  assign accept = rx_valid && rx_ready_q;

  word_assembler u_word_assembler (
    .clk_i         (clk),
    .reset_i       (reset),
    .clear_i       (asm_clear),
    .shift_i       (asm_shift),
    .byte_i        (rx_data),
    .word_o        (word),
    .word_full_c_o (word_full)
  );

  // Next-state and registered-output decode; outputs follow the next state
  // so every port is driven straight from a flop.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    chk_d      = chk_q;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (accept) begin
          len_d      = ADDR_W'(rx_data);
          word_idx_d = '0;
          chk_d      = rx_data;
          asm_clear  = 1'b1;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (accept) begin
          asm_shift = 1'b1;
          chk_d     = chk_q ^ rx_data;
          if (word_full) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (word_idx_q == len_q) begin
          state_d = ST_CHK;
        end else begin
          word_idx_d = word_idx_q + ADDR_W'(1);
          state_d    = ST_DATA;
        end
      end
      ST_CHK: begin
        if (accept) state_d = (rx_data == chk_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase

    rx_ready_d = (state_d == ST_LEN) || (state_d == ST_DATA) || (state_d == ST_CHK);
    imem_we_d  = (state_d == ST_WRITE);
    busy_d     = rx_ready_d || (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_DONE);
    done_d     = (state_d == ST_DONE);
    error_d    = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      chk_q      <= '0;
      rx_ready_q <= 1'b0;
      imem_we_q  <= 1'b0;
      cpu_hold_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      chk_q      <= chk_d;
      rx_ready_q <= rx_ready_d;
      imem_we_q  <= imem_we_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = {word_idx_q, BYTE_OFF_W'(0)};
  assign imem_wdata = word;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle CPU's writable instruction memory. It accepts a byte stream (length, instruction bytes, checksum) over a valid/ready handshake and packs it into 32-bit words. It writes those words into instruction memory at consecutive word addresses from 0, then releases the CPU from hold. It sits between the host link (UART receiver) and the instruction memory write port, and owns the CPU hold signal.

## Interface
- ADDR_W, 8, word-index width; capacity 2^ADDR_W words, matching instruction-memory indexing by Address[9:2]
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE, ERR
- rx_data  in  8  stream byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  loader can accept a byte; transfer occurs on an edge where rx_valid && rx_ready
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  ADDR_W+2  byte address = word_idx << 2
- imem_wdata  out  32  assembled instruction word
- cpu_hold  out  1  holds the CPU PC at 0 while high
- busy  out  1  load in progress (states LEN, DATA, WRITE, CHK)
- done  out  1  last load succeeded (level)
- error  out  1  last load failed checksum (level)

## Operation
- Stream format: byte 0 = L (word count minus 1, 0..2^ADDR_W-1); then 4*(L+1) data bytes, MSB first per word; then checksum byte = XOR of L and all data bytes.
- States:
  - IDLE: wait for start, then go to LEN.
  - LEN: accept L, set word_idx=0, byte_cnt=0, chk=L, then go to DATA.
  - DATA: accept a byte; word={word[23:0],byte}; chk^=byte; byte_cnt++. On the 4th byte, go to WRITE.
  - WRITE: imem_we=1 for one cycle. If word_idx==L, go to CHK; else word_idx++ and return to DATA.
  - CHK: accept one byte. Match: go to DONE. Mismatch: go to ERR.
  - DONE / ERR: on start, go to LEN.
- rx_ready=1 only in LEN, DATA, CHK. It is 0 in WRITE, so the host holds its byte and it is accepted the cycle after WRITE.
- cpu_hold=1 in every state except DONE. start from DONE reasserts hold on the next edge.
- done=1 only in DONE; error=1 only in ERR. Both clear on start.
- start while busy: ignored, no state change.
- word_idx is ADDR_W bits and never wraps. L=2^ADDR_W-1 ends at imem_addr = (2^ADDR_W-1)<<2.
- Already-written words are not cleared on error or reset; software reloads.

## Timing
- Reset values: state IDLE, rx_ready 0, imem_we 0, imem_addr 0, imem_wdata 0, cpu_hold 1, busy 0, done 0, error 0, counters and chk 0.
- start at edge t: LEN is active and rx_ready=1 from cycle t+1.
- 4th byte of a word accepted at edge k: imem_we=1 during cycle k+1, with addr and wdata stable. The memory captures at edge k+2.
- Minimum load time with rx_valid held high: 1 + 5(L+1) + 1 cycles from LEN entry to DONE entry.
- Checksum byte accepted at edge c: done or error is high and cpu_hold updated in cycle c+1.
- reset mid-operation: next cycle is IDLE with reset values. No write strobe follows reset, even if reset lands in WRITE.

## Structure
- Shared package: state encoding (IDLE, LEN, DATA, WRITE, CHK, DONE, ERR) and the default ADDR_W, both also used by the CPU top and the memory.
- Optional sub-module `word_assembler`: byte shift register plus 2-bit byte counter, producing a word_full pulse. The FSM, word_idx counter and checksum stay in imem_loader.

## Test plan
- Reset: hold reset 2 cycles, then check rx_ready=0, imem_we=0, cpu_hold=1, done=0, error=0, busy=0.
- Good load: start, then bytes 01 20 04 00 05 00 00 10 26 16 with rx_valid high. Expect:
  - writes addr 0x000 data 0x20040005, then addr 0x004 data 0x00001026
  - done=1, cpu_hold=0, error=0
- Bad checksum: same stream with final byte 17. Expect both writes, then error=1, cpu_hold=1, done=0.
- Backpressure and gaps: insert random rx_valid low cycles, and hold a byte valid through WRITE. Expect it to be accepted one cycle after WRITE; written data is identical to the good-load case.
- Reset mid-DATA after 6 data bytes: exactly one write occurred, no write after reset, state IDLE, cpu_hold=1. start is ignored while busy; a pulse mid-load changes nothing.
- Full capacity: L=FF, 1024 data bytes with the correct checksum. Expect the last write at addr 0x3FC, 256 writes total, then done=1.
